ef_psram_ahb_arbiter: RTL and testbench
=======================================

EF_PSRAM_AHB_ARBITER -- requirements
Module: ef_psram_ahb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 24: number of low HADDR bits forwarded to the slave; upper S_HADDR bits driven 0.
REQ-002 SHALL have port HCLK  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port HRESETn  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have, for x in {0,1}: Mx_HSEL in 1, Mx_HADDR in 32, Mx_HTRANS in 2, Mx_HWRITE in 1, Mx_HSIZE in 3, Mx_HWDATA in 32, Mx_HREADY in 1: AHB-Lite master-side address/data inputs.
REQ-005 SHALL have, for x in {0,1}: Mx_HREADYOUT out 1, Mx_HRDATA out 32: responses to master x.
REQ-006 SHALL have S_HSEL out 1, S_HADDR out 32, S_HTRANS out 2, S_HWRITE out 1, S_HSIZE out 3, S_HWDATA out 32, S_HREADY out 1: drive to the PSRAM controller slave.
REQ-007 SHALL have S_HREADYOUT in 1, S_HRDATA in 32: responses from the PSRAM controller slave.

Function
REQ-008 Capture: when Mx_HSEL & Mx_HTRANS[1] & Mx_HREADY at a rising edge, SHALL set pend[x] and register HADDR[AW-1:0], HWRITE and HSIZE for x.
REQ-009 SHALL ignore HTRANS IDLE/BUSY (HTRANS[1]=0); each master issues single transfers only.
REQ-010 FSM states IDLE, ADDR, DATA; IDLE->ADDR when any pend; ADDR->DATA unconditionally; DATA->ADDR on completion if the other master is pending, else DATA->IDLE.
REQ-011 Owner selection: registered on entry to ADDR; only one pending -> that master; both pending -> tie rule (REQ-024).
REQ-012 ADDR: S_HSEL=1, S_HTRANS=2'b10, S_HREADY=1, S_HADDR/S_HWRITE/S_HSIZE from owner's registered phase.
REQ-013 DATA: S_HTRANS=2'b00, S_HSEL=0, S_HREADY=S_HREADYOUT, S_HWDATA=owner's Mx_HWDATA (combinational mux, held by master while stalled).
REQ-014 IDLE: S_HTRANS=2'b00, S_HSEL=0, S_HREADY=1, S_HADDR/S_HWDATA=0.
REQ-015 Completion = DATA & S_HREADYOUT; SHALL clear pend[owner] and drive Mx_HREADYOUT=1 for the owner in that cycle, Mx_HRDATA=S_HRDATA.
REQ-016 Mx_HREADYOUT SHALL be 0 while pend[x] and not completing, 1 otherwise; Mx_HRDATA=0 when x is not completing.
REQ-017 Minimum latency: master address phase in cycle T -> Mx_HREADYOUT=1 no earlier than T+3 plus slave wait states.
REQ-018 Master issuing a new address phase in its completion cycle: new capture SHALL win over clear (pend stays 1, new phase registered).
REQ-019 Both masters capturing the same edge: both pend set, serviced back-to-back with no IDLE cycle between.
REQ-020 Non-owner capture while owner in DATA: SHALL be held, never forwarded until owner completes.

Reset
REQ-021 While HRESETn=1: state=IDLE, pend=0, registered phases=0, last-owner=1, M0/M1_HREADYOUT=1, Mx_HRDATA=0, S_HSEL=0, S_HTRANS=0, S_HREADY=1, S_HADDR/S_HWDATA/S_HSIZE/S_HWRITE=0.
REQ-022 Reset mid-transfer SHALL abort immediately with no completion pulse; the PSRAM controller SHALL share the same reset.
REQ-023 Captures SHALL resume on the first rising edge after HRESETn deasserts.

Configuration
REQ-024 Macro EF_PSRAM_ARB_RR_EN: defined -> tie granted to master not equal to last-owner (last-owner updated at each ADDR entry); undefined -> M0 always wins ties and no last-owner register exists.

Verification
REQ-025 Reset: HRESETn=1 mid-DATA of M0 read -> next cycle S_HTRANS=0, M0_HREADYOUT=1, state IDLE, no stale HRDATA.
REQ-026 M0 write 0xABCD1234 to 0x0, then M0 word read 0x0 -> M0_HRDATA=0xABCD1234; M1 idle, M1_HREADYOUT=1 throughout.
REQ-027 M0 and M1 capture same edge (M0 write 0x88776655 @0x64, M1 read @0x64) -> RR_EN: M0 first (last-owner=1 at reset), M1 reads 0x88776655; next tie goes to M1.
REQ-028 RR_EN undefined, both masters reissuing continuously -> M0 wins every tie; M1 served only when M0 not pending.
REQ-029 M1 byte writes 0x21,0x32,0x43,0x54 @0xC8..0xCB while M0 half-word writes 0xBBAA @0x12C, 0xDDCC @0x12E -> word reads return 0x54433221 and 0xDDCCBBAA.
REQ-030 M0 issues new NONSEQ in its completion cycle -> pend[0] stays 1, FSM goes DATA->ADDR (if M1 pending) or IDLE->ADDR, transfer not lost.

Source files
------------

// File: rtl/ef_psram_ahb_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single PSRAM controller slave.
// `define EF_PSRAM_ARB_RR_EN to alternate tie grants; default build gives every tie to M0.
//
// state | meaning
// IDLE  | slave bus idle, waiting for a pending request
// ADDR  | owner's registered address phase forwarded to the slave
// DATA  | slave data phase; owner's HWDATA muxed through until S_HREADYOUT
module ef_psram_ahb_arbiter #(
  parameter int AW = 24
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        M0_HSEL,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  input  logic        M0_HREADY,
  output logic        M0_HREADYOUT,
  output logic [31:0] M0_HRDATA,

  input  logic        M1_HSEL,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  input  logic        M1_HREADY,
  output logic        M1_HREADYOUT,
  output logic [31:0] M1_HRDATA,

  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    pend, pend_nxt, cap, cmpl;
  logic          owner, owner_nxt, load_owner, pick, tie_pick, completing;
  logic [AW-1:0] addr0_r, addr1_r;
  logic          write0_r, write1_r;
  logic [2:0]    size0_r, size1_r;

  assign cap[0] = M0_HSEL & M0_HTRANS[1] & M0_HREADY;
  assign cap[1] = M1_HSEL & M1_HTRANS[1] & M1_HREADY;

  assign completing = (state == ST_DATA) & S_HREADYOUT;
  assign cmpl[0]    = completing & ~owner;
  assign cmpl[1]    = completing & owner;

  // A fresh capture in the completion cycle keeps the request alive
  assign pend_nxt = cap | (pend & ~cmpl);

`ifdef EF_PSRAM_ARB_RR_EN
  logic last_owner;

  assign tie_pick = ~last_owner;

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      last_owner <= 1'b1;
    end else if (load_owner) begin
      last_owner <= pick;
    end
  end
`else
  assign tie_pick = 1'b0;
`endif

  assign pick = (pend_nxt == 2'b11) ? tie_pick : pend_nxt[1];

  always_comb begin
    state_nxt  = state;
    load_owner = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          state_nxt  = ST_ADDR;
          load_owner = 1'b1;
        end
      end
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: begin
        if (completing) begin
          if (pend_nxt[~owner]) begin
            state_nxt  = ST_ADDR;
            load_owner = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    owner_nxt = load_owner ? pick : owner;
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state    <= ST_IDLE;
      pend     <= 2'b00;
      owner    <= 1'b0;
      addr0_r  <= '0;
      addr1_r  <= '0;
      write0_r <= 1'b0;
      write1_r <= 1'b0;
      size0_r  <= 3'd0;
      size1_r  <= 3'd0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      owner <= owner_nxt;
      if (cap[0]) begin
        addr0_r  <= M0_HADDR[AW-1:0];
        write0_r <= M0_HWRITE;
        size0_r  <= M0_HSIZE;
      end
      if (cap[1]) begin
        addr1_r  <= M1_HADDR[AW-1:0];
        write1_r <= M1_HWRITE;
        size1_r  <= M1_HSIZE;
      end
    end
  end

  always_comb begin
    S_HSEL   = 1'b0;
    S_HTRANS = 2'b00;
    S_HREADY = 1'b1;
    S_HADDR  = 32'h0;
    S_HWRITE = 1'b0;
    S_HSIZE  = 3'd0;
    S_HWDATA = 32'h0;
    case (state)
      ST_ADDR: begin
        S_HSEL   = 1'b1;
        S_HTRANS = 2'b10;
        S_HADDR  = 32'(owner ? addr1_r : addr0_r);
        S_HWRITE = owner ? write1_r : write0_r;
        S_HSIZE  = owner ? size1_r : size0_r;
      end
      ST_DATA: begin
        S_HREADY = S_HREADYOUT;
        S_HWDATA = owner ? M1_HWDATA : M0_HWDATA;
      end
      default: ;
    endcase
  end

  // A master is stalled only while it has an outstanding request that is not finishing now
  assign M0_HREADYOUT = ~pend[0] | cmpl[0];
  assign M1_HREADYOUT = ~pend[1] | cmpl[1];
  assign M0_HRDATA    = cmpl[0] ? S_HRDATA : 32'h0;
  assign M1_HRDATA    = cmpl[1] ? S_HRDATA : 32'h0;

  logic unused_ok;
  assign unused_ok = ^{M0_HADDR, M0_HTRANS[0], M1_HADDR, M1_HTRANS[0]};

endmodule

// File: tb/tb_ef_psram_ahb_arbiter.sv
// Directed bench for ef_psram_ahb_arbiter: two pipelined AHB-Lite masters and a
// byte-addressed memory slave with programmable wait states.
`timescale 1ns/1ps
module tb_ef_psram_ahb_arbiter;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        m_hsel     [2];
  logic [31:0] m_haddr    [2];
  logic [1:0]  m_htrans   [2];
  logic        m_hwrite   [2];
  logic [2:0]  m_hsize    [2];
  logic [31:0] m_hwdata   [2];
  logic        m_hready   [2];
  logic        m_hreadyout[2];
  logic [31:0] m_hrdata   [2];

  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;

  assign m_hready[0] = m_hreadyout[0];
  assign m_hready[1] = m_hreadyout[1];

  ef_psram_ahb_arbiter #(.AW(24)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(m_hsel[0]), .M0_HADDR(m_haddr[0]), .M0_HTRANS(m_htrans[0]), .M0_HWRITE(m_hwrite[0]),
    .M0_HSIZE(m_hsize[0]), .M0_HWDATA(m_hwdata[0]), .M0_HREADY(m_hready[0]),
    .M0_HREADYOUT(m_hreadyout[0]), .M0_HRDATA(m_hrdata[0]),
    .M1_HSEL(m_hsel[1]), .M1_HADDR(m_haddr[1]), .M1_HTRANS(m_htrans[1]), .M1_HWRITE(m_hwrite[1]),
    .M1_HSIZE(m_hsize[1]), .M1_HWDATA(m_hwdata[1]), .M1_HREADY(m_hready[1]),
    .M1_HREADYOUT(m_hreadyout[1]), .M1_HRDATA(m_hrdata[1]),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  // Memory slave sharing the arbiter reset
  logic [7:0] mem [0:1023];
  logic       s_dp, s_w;
  logic [9:0] s_a;
  logic [2:0] s_sz;
  int         s_wait;
  int         slave_ws = 0;

  function automatic bit lane_en(input logic [1:0] a, input logic [2:0] sz, input int k);
    int nb;
    nb = 1 << sz;
    return (k >= int'(a)) && (k < int'(a) + nb);
  endfunction

  assign S_HREADYOUT = !(s_dp && s_wait != 0);
  assign S_HRDATA = s_dp ? {mem[{s_a[9:2], 2'd3}], mem[{s_a[9:2], 2'd2}],
                            mem[{s_a[9:2], 2'd1}], mem[{s_a[9:2], 2'd0}]} : 32'h0;

  always @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      s_dp <= 1'b0; s_w <= 1'b0; s_a <= '0; s_sz <= '0; s_wait <= 0;
    end else begin
      if (s_dp && S_HREADYOUT && s_w)
        for (int k = 0; k < 4; k++)
          if (lane_en(s_a[1:0], s_sz, k)) mem[{s_a[9:2], k[1:0]}] <= S_HWDATA[8*k +: 8];
      if (S_HREADY) begin
        if (S_HSEL && S_HTRANS[1]) begin
          s_dp <= 1'b1; s_a <= S_HADDR[9:0]; s_w <= S_HWRITE; s_sz <= S_HSIZE; s_wait <= slave_ws;
        end else begin
          s_dp <= 1'b0;
        end
      end else if (s_wait != 0) begin
        s_wait <= s_wait - 1;
      end
    end
  end

  int cyc = 0, fwd_cnt = 0, m1_busy_cnt = 0, m0_rd_cnt = 0;
  always @(posedge HCLK) cyc <= cyc + 1;
  always @(negedge HCLK) begin
    if (S_HSEL && S_HTRANS == 2'b10) fwd_cnt <= fwd_cnt + 1;
    if (m_hreadyout[1] !== 1'b1) m1_busy_cnt <= m1_busy_cnt + 1;
    if (m_hrdata[0] != 32'h0) m0_rd_cnt <= m0_rd_cnt + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       txq0[$], txq1[$];
  logic [31:0] rd0[$], rd1[$];
  int          lat0[$], lat1[$], done_log[$];
  int          checks = 0, errors = 0;

  task automatic enq(input int m, input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.write = w; x.size = sz; x.wdata = d << (8 * a[1:0]);
    if (m == 0) txq0.push_back(x); else txq1.push_back(x);
  endtask

  task automatic drive_addr(input int m, input xfer_t x);
    m_hsel[m] = 1'b1; m_htrans[m] = 2'b10; m_haddr[m] = x.addr;
    m_hwrite[m] = x.write; m_hsize[m] = x.size;
  endtask

  task automatic drive_idle(input int m);
    m_hsel[m] = 1'b0; m_htrans[m] = 2'b00; m_haddr[m] = 32'h0;
    m_hwrite[m] = 1'b0; m_hsize[m] = 3'd0;
  endtask

  // Pipelined master: next address is presented during the current data phase
  task automatic master_run(input int m);
    xfer_t q[$];
    xfer_t cur;
    int n, i, guard, t_acc, t_cur;
    bit dp, ad;
    logic hr;
    if (m == 0) q = txq0; else q = txq1;
    n = q.size(); i = 0; guard = 0; dp = 0; ad = 0; t_acc = 0; t_cur = 0;
    if (n > 0) begin drive_addr(m, q[0]); ad = 1; end
    while ((ad || dp) && guard < 300) begin
      @(negedge HCLK);
      hr = m_hreadyout[m];
      if (hr && dp) begin
        done_log.push_back(m);
        if (m == 0) begin rd0.push_back(m_hrdata[0]); lat0.push_back(cyc - t_cur); end
        else        begin rd1.push_back(m_hrdata[1]); lat1.push_back(cyc - t_cur); end
      end
      if (hr && ad) t_acc = cyc;
      @(posedge HCLK); #1;
      guard++;
      if (hr) begin
        dp = ad;
        if (ad) begin cur = q[i]; i++; t_cur = t_acc; m_hwdata[m] = cur.wdata; end
        ad = (i < n);
        if (ad) drive_addr(m, q[i]); else drive_idle(m);
      end
    end
    drive_idle(m);
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL master%0d_timeout got=%0d cycles exp=<300", m, guard);
    end
  endtask

  task automatic apply_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    drive_idle(0); drive_idle(1);
    m_hwdata[0] = 32'h0; m_hwdata[1] = 32'h0;
    txq0.delete(); txq1.delete(); rd0.delete(); rd1.delete();
    lat0.delete(); lat1.delete(); done_log.delete();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge HCLK);
    checks++;
    if ({m_hreadyout[0], m_hreadyout[1]} !== 2'b11) begin
      errors++; $display("FAIL reset_hreadyout got=%b exp=11", {m_hreadyout[0], m_hreadyout[1]});
    end
    checks++;
    if ({m_hrdata[0], m_hrdata[1]} !== 64'h0) begin
      errors++; $display("FAIL reset_hrdata got=%h exp=0", {m_hrdata[0], m_hrdata[1]});
    end
    checks++;
    if ({S_HSEL, S_HTRANS, S_HREADY} !== 4'b0001) begin
      errors++; $display("FAIL reset_sctl got=%b exp=0001", {S_HSEL, S_HTRANS, S_HREADY});
    end
    checks++;
    if ({S_HADDR, S_HWDATA, S_HSIZE, S_HWRITE} !== 68'h0) begin
      errors++; $display("FAIL reset_sbus got=%h exp=0", {S_HADDR, S_HWDATA, S_HSIZE, S_HWRITE});
    end
  endtask

  task automatic test_write_read();
    int mb, fb;
    apply_reset();
    slave_ws = 0;
    mb = m1_busy_cnt; fb = fwd_cnt;
    enq(0, 32'h0, 1'b1, 3'd2, 32'hABCD1234);
    enq(0, 32'h0, 1'b0, 3'd2, 32'h0);
    master_run(0);
    checks++;
    if (rd0[1] !== 32'hABCD1234) begin errors++; $display("FAIL wr_rd_data got=%h exp=abcd1234", rd0[1]); end
    checks++;
    if (lat0[0] !== 3) begin errors++; $display("FAIL wr_min_latency got=%0d exp=3", lat0[0]); end
    checks++;
    if (lat0[1] !== 3) begin errors++; $display("FAIL reissue_latency got=%0d exp=3", lat0[1]); end
    checks++;
    if (m1_busy_cnt - mb !== 0) begin errors++; $display("FAIL m1_idle_ready got=%0d exp=0", m1_busy_cnt - mb); end
    checks++;
    if (fwd_cnt - fb !== 2) begin errors++; $display("FAIL wr_rd_fwd got=%0d exp=2", fwd_cnt - fb); end
  endtask

  task automatic test_wait_states();
    apply_reset();
    slave_ws = 2;
    enq(1, 32'h0, 1'b0, 3'd2, 32'h0);
    master_run(1);
    slave_ws = 0;
    checks++;
    if (rd1[0] !== 32'hABCD1234) begin errors++; $display("FAIL ws_data got=%h exp=abcd1234", rd1[0]); end
    checks++;
    if (lat1[0] !== 5) begin errors++; $display("FAIL ws_latency got=%0d exp=5", lat1[0]); end
  endtask

  task automatic test_tie();
    int fb;
    apply_reset();
    fb = fwd_cnt;
    enq(0, 32'h64, 1'b1, 3'd2, 32'h88776655);
    enq(1, 32'h64, 1'b0, 3'd2, 32'h0);
    fork master_run(0); master_run(1); join
    checks++;
    if (done_log.size() !== 2 || done_log[0] !== 0 || done_log[1] !== 1) begin
      errors++; $display("FAIL tie_order got=%p exp='{0,1}", done_log);
    end
    checks++;
    if (rd1[0] !== 32'h88776655) begin errors++; $display("FAIL tie_m1_data got=%h exp=88776655", rd1[0]); end
    checks++;
    if (lat0[0] !== 3) begin errors++; $display("FAIL tie_m0_latency got=%0d exp=3", lat0[0]); end
    checks++;
    if (lat1[0] !== 5) begin errors++; $display("FAIL tie_b2b_latency got=%0d exp=5", lat1[0]); end
    checks++;
    if (fwd_cnt - fb !== 2) begin errors++; $display("FAIL tie_fwd got=%0d exp=2", fwd_cnt - fb); end
  endtask

  task automatic test_continuous();
    int exp_order [5];
`ifdef EF_PSRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 1, 1};
`endif
    apply_reset();
    enq(0, 32'h200, 1'b1, 3'd2, 32'h1);
    enq(0, 32'h204, 1'b1, 3'd2, 32'h2);
    enq(0, 32'h208, 1'b1, 3'd2, 32'h3);
    enq(1, 32'h200, 1'b0, 3'd2, 32'h0);
    enq(1, 32'h204, 1'b0, 3'd2, 32'h0);
    fork master_run(0); master_run(1); join
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= done_log.size() || done_log[i] !== exp_order[i]) begin
        errors++; $display("FAIL cont_order[%0d] got=%p exp=%0d", i, done_log, exp_order[i]);
      end
    end
    checks++;
    if (rd1[0] !== 32'h1 || rd1[1] !== 32'h2) begin
      errors++; $display("FAIL cont_m1_data got=%h,%h exp=1,2", rd1[0], rd1[1]);
    end
  endtask

  task automatic test_byte_lanes();
    apply_reset();
    enq(1, 32'hC8, 1'b1, 3'd0, 32'h21);
    enq(1, 32'hC9, 1'b1, 3'd0, 32'h32);
    enq(1, 32'hCA, 1'b1, 3'd0, 32'h43);
    enq(1, 32'hCB, 1'b1, 3'd0, 32'h54);
    enq(0, 32'h12C, 1'b1, 3'd1, 32'hBBAA);
    enq(0, 32'h12E, 1'b1, 3'd1, 32'hDDCC);
    fork master_run(0); master_run(1); join
    txq0.delete(); txq1.delete(); rd0.delete(); rd1.delete();
    enq(0, 32'hC8, 1'b0, 3'd2, 32'h0);
    enq(1, 32'h12C, 1'b0, 3'd2, 32'h0);
    fork master_run(0); master_run(1); join
    checks++;
    if (rd0[0] !== 32'h54433221) begin errors++; $display("FAIL byte_word got=%h exp=54433221", rd0[0]); end
    checks++;
    if (rd1[0] !== 32'hDDCCBBAA) begin errors++; $display("FAIL half_word got=%h exp=ddccbbaa", rd1[0]); end
  endtask

  task automatic test_reset_mid();
    int fb, rb;
    apply_reset();
    slave_ws = 6;
    m_hsel[0] = 1'b1; m_htrans[0] = 2'b10; m_haddr[0] = 32'h64; m_hwrite[0] = 1'b0; m_hsize[0] = 3'd2;
    @(posedge HCLK); #1;
    drive_idle(0);
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if ({m_hreadyout[0], S_HREADY} !== 2'b00) begin
      errors++; $display("FAIL mid_stalled got=%b exp=00", {m_hreadyout[0], S_HREADY});
    end
    #1 HRESETn = 1'b1;
    #1;
    checks++;
    if ({S_HSEL, S_HTRANS, S_HREADY} !== 4'b0001) begin
      errors++; $display("FAIL mid_abort_sctl got=%b exp=0001", {S_HSEL, S_HTRANS, S_HREADY});
    end
    checks++;
    if (m_hreadyout[0] !== 1'b1) begin errors++; $display("FAIL mid_abort_ready got=%b exp=1", m_hreadyout[0]); end
    checks++;
    if (m_hrdata[0] !== 32'h0) begin errors++; $display("FAIL mid_abort_rdata got=%h exp=0", m_hrdata[0]); end
    @(posedge HCLK);
    #1 HRESETn = 1'b0;
    slave_ws = 0;
    fb = fwd_cnt; rb = m0_rd_cnt;
    repeat (6) @(posedge HCLK);
    #1;
    checks++;
    if (fwd_cnt - fb !== 0) begin errors++; $display("FAIL mid_no_replay got=%0d exp=0", fwd_cnt - fb); end
    checks++;
    if (m0_rd_cnt - rb !== 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", m0_rd_cnt - rb); end
    apply_reset();
    enq(0, 32'h64, 1'b0, 3'd2, 32'h0);
    master_run(0);
    checks++;
    if (rd0[0] !== 32'h88776655) begin errors++; $display("FAIL resume_data got=%h exp=88776655", rd0[0]); end
    checks++;
    if (lat0[0] !== 3) begin errors++; $display("FAIL resume_latency got=%0d exp=3", lat0[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle(0); drive_idle(1);
    m_hwdata[0] = 32'h0; m_hwdata[1] = 32'h0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_tie();
    test_continuous();
    test_byte_lanes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
